// File: rtl/mem_arbiter.sv
// Two-master (ibus/dbus) arbiter onto one shared memory port, with a latched request register.
// Optional starvation guard for ibus is enabled by defining ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps

package mem_arbiter_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output dbus_req_t  mreq,
    input  dbus_resp_t mresp,
    output logic [1:0] owner,
    output logic       busy
);
    // State encoding doubles as the owner code, so owner comes straight from the register.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10
    } state_t;

    state_t    state, state_next;
    dbus_req_t req_q, req_next;
    logic      busy_q;
    logic      grant_i, grant_d;
    logic      starved;

    // An out-of-range limit references a nonexistent module and stops elaboration.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        illegal_starve_limit_parameter u_bad ();
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign starved = (starve_cnt == 4'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && ireq.valid) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign starved = 1'b0;
`endif

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        req_next   = req_q;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ireq.valid && (starved || !dreq.valid)) begin
                    grant_i         = 1'b1;
                    state_next      = I_BUSY;
                    req_next        = '0;
                    req_next.valid  = 1'b1;
                    req_next.addr   = ireq.addr;
                    req_next.size   = MSIZE4;
                end else if (dreq.valid) begin
                    grant_d    = 1'b1;
                    state_next = D_BUSY;
                    req_next   = dreq;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mresp.data_ok) begin
                    state_next = IDLE;
                    req_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the request register is reset too, because mreq is driven from it and must read zero in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            req_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            req_q  <= req_next;
            busy_q <= (state_next != IDLE);
        end
    end

    assign owner = state;
    assign busy  = busy_q;
    assign mreq  = req_q;

    // Only the current owner sees handshakes; ibus picks its 32-bit half by the latched addr[2].
    always_comb begin
        iresp      = '0;
        dresp      = '0;
        dresp.data = mresp.data;
        if (state == I_BUSY) begin
            iresp.addr_ok = mresp.addr_ok;
            iresp.data_ok = mresp.data_ok;
            iresp.data    = req_q.addr[2] ? mresp.data[63:32] : mresp.data[31:0];
        end
        if (state == D_BUSY) begin
            dresp.addr_ok = mresp.addr_ok;
            dresp.data_ok = mresp.data_ok;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, fetches, priority/starvation, withdraw and mid-transaction reset.
`timescale 1ns/1ps

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  mreq;
    dbus_resp_t mresp;
    logic [1:0] owner;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .mreq  (mreq),
        .mresp (mresp),
        .owner (owner),
        .busy  (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ireq  = '0;
        dreq  = '0;
        mresp = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset      = 1'b0;
        ireq.valid = 1'b1;
        ireq.addr  = 32'h8000_0000;
        dreq.valid = 1'b1;
        dreq.addr  = 32'h8000_0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b expected 00", owner); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
            checks++;
            if (mreq !== '0) begin errors++; $display("FAIL reset_mreq: got %h expected 0", mreq); end
        end
        reset      = 1'b1;
        dreq.valid = 1'b0;
        tick();
        checks++;
        if (owner !== 2'b01) begin errors++; $display("FAIL first_grant_owner: got %b expected 01", owner); end
        mresp.data_ok = 1'b1;
        ireq.valid    = 1'b0;
        tick();
        mresp = '0;
        checks++;
        if (owner !== 2'b00) begin errors++; $display("FAIL first_grant_done: got %b expected 00", owner); end
        clear_inputs();
    endtask

    task automatic test_single_fetch(input logic [31:0] addr, input logic [63:0] mdata,
                                     input logic [31:0] exp_data);
        clear_inputs();
        ireq.valid = 1'b1;
        ireq.addr  = addr;
        tick();
        checks++;
        if (owner !== 2'b01) begin errors++; $display("FAIL fetch_owner: got %b expected 01", owner); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy: got %b expected 1", busy); end
        checks++;
        if (mreq.valid !== 1'b1 || mreq.addr !== addr) begin
            errors++; $display("FAIL fetch_mreq_addr: got %b/%h expected 1/%h", mreq.valid, mreq.addr, addr);
        end
        checks++;
        if (mreq.size !== MSIZE4 || mreq.strobe !== 8'h00 || mreq.data !== 64'h0) begin
            errors++; $display("FAIL fetch_mreq_fields: got size %0d strobe %h data %h expected 2/00/0",
                               mreq.size, mreq.strobe, mreq.data);
        end
        tick();
        tick();
        checks++;
        if (owner !== 2'b01) begin errors++; $display("FAIL fetch_hold: got %b expected 01", owner); end
        mresp.data_ok = 1'b1;
        mresp.data    = mdata;
        ireq.valid    = 1'b0;
        #1;
        checks++;
        if (iresp.data_ok !== 1'b1 || iresp.data !== exp_data) begin
            errors++; $display("FAIL fetch_iresp: got %b/%h expected 1/%h", iresp.data_ok, iresp.data, exp_data);
        end
        checks++;
        if (dresp.data_ok !== 1'b0) begin errors++; $display("FAIL fetch_dresp_quiet: got %b expected 0", dresp.data_ok); end
        tick();
        mresp = '0;
        checks++;
        if (owner !== 2'b00 || busy !== 1'b0 || mreq !== '0) begin
            errors++; $display("FAIL fetch_idle: got owner %b busy %b mreq %h expected 00/0/0", owner, busy, mreq);
        end
    endtask

    task automatic test_simultaneous();
        clear_inputs();
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h8000_1000;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h0123_4567_89AB_CDEF;
        ireq.valid  = 1'b1;
        ireq.addr   = 32'h8000_0010;
        tick();
        checks++;
        if (owner !== 2'b10) begin errors++; $display("FAIL simul_dbus_first: got %b expected 10", owner); end
        checks++;
        if (mreq.addr !== 32'h8000_1000 || mreq.strobe !== 8'hFF || mreq.data !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL simul_mreq: got %h/%h/%h expected 80001000/ff/0123456789abcdef",
                               mreq.addr, mreq.strobe, mreq.data);
        end
        mresp.addr_ok = 1'b1;
        mresp.data    = 64'h5555_6666_7777_8888;
        #1;
        checks++;
        if (iresp !== '0) begin errors++; $display("FAIL simul_iresp_quiet_a: got %h expected 0", iresp); end
        checks++;
        if (dresp.addr_ok !== 1'b1) begin errors++; $display("FAIL simul_dresp_addr_ok: got %b expected 1", dresp.addr_ok); end
        tick();
        mresp.addr_ok = 1'b0;
        mresp.data_ok = 1'b1;
        mresp.data    = 64'h9999_AAAA_BBBB_CCCC;
        dreq.valid    = 1'b0;
        #1;
        checks++;
        if (dresp.data_ok !== 1'b1 || dresp.data !== 64'h9999_AAAA_BBBB_CCCC) begin
            errors++; $display("FAIL simul_dresp: got %b/%h expected 1/9999aaaabbbbcccc", dresp.data_ok, dresp.data);
        end
        checks++;
        if (iresp !== '0) begin errors++; $display("FAIL simul_iresp_quiet_b: got %h expected 0", iresp); end
        tick();
        mresp = '0;
        checks++;
        if (owner !== 2'b00) begin errors++; $display("FAIL simul_turnaround: got %b expected 00", owner); end
        tick();
        checks++;
        if (owner !== 2'b01 || mreq.addr !== 32'h8000_0010) begin
            errors++; $display("FAIL simul_ibus_second: got %b/%h expected 01/80000010", owner, mreq.addr);
        end
        mresp.data_ok = 1'b1;
        mresp.data    = 64'hAAAA_BBBB_CCCC_DDDD;
        ireq.valid    = 1'b0;
        #1;
        checks++;
        if (iresp.data !== 32'hCCCC_DDDD) begin errors++; $display("FAIL simul_iresp_low: got %h expected ccccdddd", iresp.data); end
        tick();
        mresp = '0;
        clear_inputs();
    endtask

    task automatic test_priority();
        logic [1:0] exp_order [6];
`ifdef ARB_STARVE_GUARD_EN
        exp_order = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
`else
        exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
        clear_inputs();
        ireq.valid = 1'b1;
        ireq.addr  = 32'h8000_0020;
        dreq.valid = 1'b1;
        dreq.addr  = 32'h8000_4000;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (owner !== exp_order[i]) begin
                errors++; $display("FAIL priority_grant_%0d: got %b expected %b", i, owner, exp_order[i]);
            end
            mresp.data_ok = 1'b1;
            tick();
            mresp.data_ok = 1'b0;
            checks++;
            if (owner !== 2'b00) begin errors++; $display("FAIL priority_idle_%0d: got %b expected 00", i, owner); end
        end
        clear_inputs();
    endtask

    task automatic test_withdraw();
        clear_inputs();
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h8000_2000;
        dreq.size   = MSIZE4;
        dreq.strobe = 8'h0F;
        dreq.data   = 64'h0000_0000_CAFE_F00D;
        tick();
        checks++;
        if (owner !== 2'b10) begin errors++; $display("FAIL withdraw_grant: got %b expected 10", owner); end
        dreq.valid = 1'b0;
        dreq.addr  = 32'h8000_3000;
        tick();
        checks++;
        if (mreq.valid !== 1'b1 || mreq.addr !== 32'h8000_2000) begin
            errors++; $display("FAIL withdraw_mreq_stable: got %b/%h expected 1/80002000", mreq.valid, mreq.addr);
        end
        mresp.data_ok = 1'b1;
        mresp.data    = 64'h1234_5678_0000_0000;
        #1;
        checks++;
        if (dresp.data_ok !== 1'b1 || dresp.data !== 64'h1234_5678_0000_0000) begin
            errors++; $display("FAIL withdraw_dresp: got %b/%h expected 1/1234567800000000", dresp.data_ok, dresp.data);
        end
        tick();
        mresp = '0;
        checks++;
        if (owner !== 2'b00 || mreq !== '0) begin
            errors++; $display("FAIL withdraw_idle: got %b/%h expected 00/0", owner, mreq);
        end
        tick();
        checks++;
        if (owner !== 2'b00) begin errors++; $display("FAIL withdraw_no_regrant: got %b expected 00", owner); end
    endtask

    task automatic test_mid_reset();
        clear_inputs();
        dreq.valid = 1'b1;
        dreq.addr  = 32'h8000_5000;
        tick();
        checks++;
        if (owner !== 2'b10) begin errors++; $display("FAIL midrst_grant: got %b expected 10", owner); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (owner !== 2'b00 || busy !== 1'b0 || mreq !== '0) begin
            errors++; $display("FAIL midrst_async: got %b/%b/%h expected 00/0/0", owner, busy, mreq);
        end
        dreq = '0;
        tick();
        reset = 1'b1;
        tick();
        mresp.addr_ok = 1'b1;
        mresp.data_ok = 1'b1;
        mresp.data    = 64'hFFFF_EEEE_DDDD_CCCC;
        #1;
        checks++;
        if (dresp.data_ok !== 1'b0 || dresp.addr_ok !== 1'b0 || iresp.data_ok !== 1'b0 || iresp.addr_ok !== 1'b0) begin
            errors++; $display("FAIL midrst_late_resp: got d %b/%b i %b/%b expected all 0",
                               dresp.addr_ok, dresp.data_ok, iresp.addr_ok, iresp.data_ok);
        end
        tick();
        mresp = '0;
        checks++;
        if (owner !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_stay_idle: got %b/%b expected 00/0", owner, busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_fetch(32'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);
        test_single_fetch(32'h8000_0008, 64'h1111_2222_3333_4444, 32'h3333_4444);
        test_simultaneous();
        test_priority();
        test_withdraw();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive dbus grants while ibus is waiting (used only when ARB_STARVE_GUARD_EN is defined); legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port ireq  input  ibus_req_t  instruction-fetch request (valid, addr).
REQ-005 The block SHALL have port iresp  output  ibus_resp_t  instruction-fetch response (addr_ok, data_ok, 32-bit data).
REQ-006 The block SHALL have port dreq  input  dbus_req_t  data request (valid, addr, size, strobe, data).
REQ-007 The block SHALL have port dresp  output  dbus_resp_t  data response (addr_ok, data_ok, 64-bit data).
REQ-008 The block SHALL have port mreq  output  dbus_req_t  shared memory-port request.
REQ-009 The block SHALL have port mresp  input  dbus_resp_t  shared memory-port response.
REQ-010 The block SHALL have port owner  output  2  current grant: 00 none, 01 ibus, 10 dbus.
REQ-011 The block SHALL have port busy  output  1  high while a transaction is outstanding on mreq.

Function
REQ-012 FSM states SHALL be IDLE, I_BUSY and D_BUSY.
REQ-013 In IDLE the arbiter SHALL grant as follows: if dreq.valid, go to D_BUSY; else if ireq.valid, go to I_BUSY; else stay in IDLE.
REQ-014 On entering a BUSY state, the granted request fields SHALL be latched into a request register.
- ibus fields: addr; size = MSIZE4; strobe = 0; data = 0.
- dbus fields: all fields as presented.
REQ-015 mreq SHALL be driven only from the latched register, so request fields are stable for the whole transaction.
- mreq.valid = busy.
- In IDLE, mreq SHALL be all zero.
REQ-016 Grant latency SHALL be exactly 1 cycle: a request seen in IDLE at edge N appears on mreq in cycle N+1.
REQ-017 Responses SHALL be routed combinationally to the owner only.
- mresp.addr_ok and mresp.data_ok go to the owner.
- The non-owner SHALL see addr_ok=0 and data_ok=0.
REQ-018 iresp.data SHALL be selected from mresp.data by the latched addr[2].
- addr[2]=1: mresp.data[63:32].
- addr[2]=0: mresp.data[31:0].
REQ-019 dresp.data SHALL equal mresp.data.
REQ-020 On mresp.data_ok in a BUSY state, the FSM SHALL return to IDLE at the next edge, giving one idle turnaround cycle.
- No back-to-back grant without passing through IDLE.
REQ-021 If the owner drops valid before data_ok, the transaction SHALL continue unchanged until data_ok; the response is still routed to that owner.
REQ-022 Requests arriving while BUSY SHALL be ignored until the FSM is back in IDLE; requesters hold valid until data_ok.
REQ-023 When dreq.valid and ireq.valid are both high in IDLE, the tie SHALL be resolved per REQ-013 or REQ-029.
REQ-024 mresp.addr_ok SHALL NOT change FSM state; only data_ok ends a transaction.
REQ-025 owner and busy SHALL be registered outputs consistent with the FSM state.

Reset
REQ-026 While reset is low, all of the following SHALL hold immediately, without waiting for clk:
- FSM in IDLE.
- owner = 00 and busy = 0.
- request register and mreq all zero.
- starvation counter = 0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction; after release the arbiter SHALL behave as from power-up, and a late mresp.data_ok SHALL be ignored.
REQ-028 The first grant after reset release SHALL occur at the first rising edge where reset is high and a valid is present.

Configuration
REQ-029 With macro ARB_STARVE_GUARD_EN defined, a 4-bit starvation counter SHALL be active.
- Increments on each dbus grant made while ireq.valid is high.
- Clears on each ibus grant.
- When the counter equals STARVE_LIMIT and ireq.valid is high in IDLE, ibus SHALL be granted even if dreq.valid is high.
REQ-030 Without ARB_STARVE_GUARD_EN, the counter SHALL NOT exist, priority SHALL be fixed with dbus first, and STARVE_LIMIT SHALL be ignored.

Verification
REQ-031 Reset scenario: hold reset low with ireq.valid=1 and dreq.valid=1 -> owner=00, busy=0, mreq.valid=0 throughout.
REQ-032 Single fetch scenario: ireq addr=0x8000_0004; mresp.data_ok after 3 cycles with data 0x11112222_33334444 -> mreq in cycle 1 with size=MSIZE4, strobe=0; iresp.data=0x11112222; FSM back in IDLE one cycle later.
REQ-033 Simultaneous request scenario (guard off): dreq store to addr=0x8000_1000, strobe=0xFF, with a fetch pending -> dbus served first; ibus granted on the second edge after dbus data_ok; iresp stays 0 during the dbus transaction.
REQ-034 Starvation scenario (guard on, STARVE_LIMIT=2): dreq.valid and ireq.valid held high -> grant order dbus, dbus, ibus, dbus, dbus, ibus.
REQ-035 Withdraw scenario: dbus drops valid and changes addr the cycle after grant -> mreq.addr unchanged until data_ok, and dresp.data_ok is delivered.
REQ-036 Mid-transaction reset scenario: assert reset in D_BUSY, release, then pulse mresp.data_ok=1 -> no response on dresp or iresp, and FSM stays IDLE.
